// File: rtl/inst_mem_loader.sv
// Instruction store ahead of the control unit: cleared, then loaded through a
// valid/ready port, then read at the PC address while run is high.
module inst_mem_loader #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 12,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              load_done,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] inst,
   output logic              run,
   output logic              past_end,
   output logic [ADDR_W:0]   prog_len,
   output logic              wr_reject
);
   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;

   localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] wr_ptr;

   logic              xfer;
   logic [ADDR_W:0]   len_nxt;
   logic              in_range;

   assign xfer     = wr_valid & wr_ready & (state == LOAD);
   assign len_nxt  = prog_len + {{ADDR_W{1'b0}}, xfer};
   assign in_range = {1'b0, addr} < prog_len;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         clr_ptr   <= '0;
         wr_ptr    <= '0;
         prog_len  <= '0;
         inst      <= '0;
         wr_ready  <= 1'b0;
         run       <= 1'b0;
         past_end  <= 1'b0;
         wr_reject <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // Sticky; the clears on entry into CLEAR below take precedence.
         if (wr_valid && state != LOAD) wr_reject <= 1'b1;

         case (state)
            IDLE: begin
               inst     <= '0;
               past_end <= 1'b0;
               if (load_start) begin
                  state     <= CLEAR;
                  clr_ptr   <= '0;
                  prog_len  <= '0;
                  wr_reject <= 1'b0;
               end
            end

            CLEAR: begin
               inst         <= '0;
               past_end     <= 1'b0;
               mem[clr_ptr] <= '0;
               clr_ptr      <= clr_ptr + 1'b1;
               if (clr_ptr == LAST) begin
                  state    <= LOAD;
                  wr_ptr   <= '0;
                  wr_ready <= 1'b1;
               end
            end

            LOAD: begin
               inst     <= '0;
               past_end <= 1'b0;
               if (xfer) begin
                  mem[wr_ptr] <= wr_data;
                  wr_ptr      <= wr_ptr + 1'b1;
                  prog_len    <= len_nxt;
               end
               // Full is judged on the count, so wr_ptr never wraps onto entry 0.
               if (len_nxt == FULL || (load_done && len_nxt != '0)) begin
                  state    <= RUN;
                  run      <= 1'b1;
                  wr_ready <= 1'b0;
               end else if (load_done) begin
                  state    <= IDLE;
                  wr_ready <= 1'b0;
               end
            end

            RUN: begin
               if (load_start) begin
                  state     <= CLEAR;
                  run       <= 1'b0;
                  inst      <= '0;
                  past_end  <= 1'b0;
                  prog_len  <= '0;
                  clr_ptr   <= '0;
                  wr_reject <= 1'b0;
               end else begin
                  inst     <= in_range ? mem[addr] : '0;
                  past_end <= !in_range;
               end
            end

            default: begin
               state    <= IDLE;
               run      <= 1'b0;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: stimulus queues expected field values
// with a due cycle; a negedge monitor pops and compares them.
module tb_inst_mem_loader;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 12;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              load_start = 1'b0;
   logic              load_done = 1'b0;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic              wr_ready;
   logic [DATA_W-1:0] inst;
   logic              run;
   logic              past_end;
   logic [ADDR_W:0]   prog_len;
   logic              wr_reject;

   inst_mem_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .addr(addr),
      .inst(inst), .run(run), .past_end(past_end), .prog_len(prog_len),
      .wr_reject(wr_reject)
   );

   always #5 clk = ~clk;

   typedef enum int {F_INST, F_RUN, F_PE, F_RDY, F_REJ, F_LEN} fld_t;
   typedef struct {
      string       name;
      int          due;
      fld_t        fld;
      logic [31:0] val;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [11:0] prog8 [8];
   logic [11:0] prog5 [5];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(fld_t f);
      case (f)
         F_INST:  return {20'd0, inst};
         F_RUN:   return {31'd0, run};
         F_PE:    return {31'd0, past_end};
         F_RDY:   return {31'd0, wr_ready};
         F_REJ:   return {31'd0, wr_reject};
         F_LEN:   return {28'd0, prog_len};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic cmp(string name, fld_t f, logic [31:0] val);
      logic [31:0] a;
      a = actual(f);
      checks++;
      if (a !== val) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, a, val, cyc);
      end
   endtask

   task automatic expect_at(string n, int dly, fld_t f, logic [31:0] v);
      exp_t e;
      e.name = n; e.due = cyc + dly; e.fld = f; e.val = v;
      q.push_back(e);
   endtask

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!wr_ready && n < 20) begin
         step();
         n++;
      end
      cmp("wait_ready", F_RDY, 1);
   endtask

   // Monitor: compare every queued expectation that has come due.
   initial begin
      forever begin
         int i;
         @(negedge clk);
         i = 0;
         while (i < q.size()) begin
            if (q[i].due <= cyc) begin
               cmp(q[i].name, q[i].fld, q[i].val);
               q.delete(i);
            end else begin
               i++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      prog8[0] = 12'h201; prog8[1] = 12'h402; prog8[2] = 12'h603; prog8[3] = 12'h804;
      prog8[4] = 12'hA05; prog8[5] = 12'hC06; prog8[6] = 12'hE07; prog8[7] = 12'hE08;
      prog5[0] = 12'h111; prog5[1] = 12'h222; prog5[2] = 12'h333; prog5[3] = 12'h444;
      prog5[4] = 12'h555;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      expect_at("rst_inst", 0, F_INST, 0);
      expect_at("rst_run", 0, F_RUN, 0);
      expect_at("rst_pe", 0, F_PE, 0);
      expect_at("rst_rdy", 0, F_RDY, 0);
      expect_at("rst_rej", 0, F_REJ, 0);
      expect_at("rst_len", 0, F_LEN, 0);
      step();
      reset = 1'b1;

      // Full 8-word load: CLEAR lasts exactly 8 cycles
      load_start = 1'b1;
      for (int k = 1; k <= 8; k++) expect_at("clear_rdy_lo", k, F_RDY, 0);
      expect_at("clear_rdy_hi", 9, F_RDY, 1);
      step();
      load_start = 1'b0;
      step(8);
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_data  = prog8[i];
         if (i == 7) begin
            expect_at("full_run_lo", 0, F_RUN, 0);
            expect_at("full_run", 1, F_RUN, 1);
            expect_at("full_len", 1, F_LEN, 8);
            expect_at("full_rdy_drop", 1, F_RDY, 0);
         end
         step();
      end
      // Extra word past full: rejected, entry 0 not overwritten
      wr_data = 12'hFFF;
      addr    = 3'd0;
      expect_at("nowrap_rej", 1, F_REJ, 1);
      expect_at("nowrap_inst0", 1, F_INST, 12'h201);
      step();
      wr_valid = 1'b0;
      addr = 3'd5;
      expect_at("fetch5", 1, F_INST, 12'hC06);
      expect_at("fetch5_pe", 1, F_PE, 0);
      step();
      addr = 3'd7;
      expect_at("fetch7", 1, F_INST, 12'hE08);
      step();

      // Reload from RUN: 3 words, load_done with the 3rd
      load_start = 1'b1;
      expect_at("rerun_run0", 1, F_RUN, 0);
      expect_at("rerun_inst0", 1, F_INST, 0);
      expect_at("rerun_len0", 1, F_LEN, 0);
      expect_at("rerun_rej_clr", 1, F_REJ, 0);
      step();
      load_start = 1'b0;
      wait_ready();
      wr_valid = 1'b1; wr_data = 12'h123; step();
      wr_data = 12'h456; step();
      wr_data = 12'h789; load_done = 1'b1;
      expect_at("ld3_len", 1, F_LEN, 3);
      expect_at("ld3_run", 1, F_RUN, 1);
      expect_at("ld3_rdy", 1, F_RDY, 0);
      step();
      wr_valid = 1'b0; load_done = 1'b0;
      addr = 3'd2;
      expect_at("ld3_fetch2", 1, F_INST, 12'h789);
      expect_at("ld3_pe2", 1, F_PE, 0);
      step();
      addr = 3'd3;
      expect_at("ld3_fetch3", 1, F_INST, 0);
      expect_at("ld3_pe3", 1, F_PE, 1);
      step();

      // Empty load then load_done -> IDLE
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      wait_ready();
      load_done = 1'b1;
      expect_at("empty_run", 1, F_RUN, 0);
      expect_at("empty_len", 1, F_LEN, 0);
      expect_at("empty_rdy", 1, F_RDY, 0);
      expect_at("empty_idle_rdy", 2, F_RDY, 0);
      step();
      load_done = 1'b0;
      step();

      // Write attempt in IDLE
      wr_valid = 1'b1; wr_data = 12'hFFF;
      expect_at("idle_rej", 1, F_REJ, 1);
      step();
      wr_valid = 1'b0;

      // New 1-word load; load_start clears wr_reject
      load_start = 1'b1;
      expect_at("start_rej_clr", 1, F_REJ, 0);
      step();
      load_start = 1'b0;
      wait_ready();
      wr_valid = 1'b1; wr_data = 12'h0AB; load_done = 1'b1;
      expect_at("ld1_len", 1, F_LEN, 1);
      expect_at("ld1_run", 1, F_RUN, 1);
      step();
      wr_valid = 1'b0; load_done = 1'b0;
      addr = 3'd0;
      expect_at("ld1_fetch0", 1, F_INST, 12'h0AB);
      step();
      // Write attempt in RUN: flagged, memory unchanged
      wr_valid = 1'b1; wr_data = 12'hFFF;
      expect_at("run_rej", 1, F_REJ, 1);
      expect_at("run_rej_inst", 1, F_INST, 12'h0AB);
      step();
      wr_valid = 1'b0;
      addr = 3'd1;
      expect_at("ld1_fetch1", 1, F_INST, 0);
      expect_at("ld1_pe1", 1, F_PE, 1);
      step();

      // Asynchronous reset mid-load after 2 of 5 words
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      wait_ready();
      wr_valid = 1'b1; wr_data = prog5[0]; step();
      wr_data = prog5[1]; step();
      wr_data = prog5[2];
      #2;
      reset = 1'b0;
      #1;
      cmp("async_rdy", F_RDY, 0);
      cmp("async_len", F_LEN, 0);
      cmp("async_run", F_RUN, 0);
      cmp("async_inst", F_INST, 0);
      cmp("async_pe", F_PE, 0);
      cmp("async_rej", F_REJ, 0);
      wr_valid = 1'b0;
      step();
      reset = 1'b1;

      // Reload after reset
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      wait_ready();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = prog5[i];
         if (i == 4) begin
            load_done = 1'b1;
            expect_at("ld5_len", 1, F_LEN, 5);
            expect_at("ld5_run", 1, F_RUN, 1);
         end
         step();
      end
      wr_valid = 1'b0; load_done = 1'b0;
      addr = 3'd4;
      expect_at("ld5_fetch4", 1, F_INST, 12'h555);
      step();
      addr = 3'd1;
      expect_at("ld5_fetch1", 1, F_INST, 12'h222);
      step();
      addr = 3'd5;
      expect_at("ld5_fetch5", 1, F_INST, 0);
      expect_at("ld5_pe5", 1, F_PE, 1);
      step();

      // Drain the scoreboard
      for (int n = 0; n < 5 && q.size() != 0; n++) step();
      while (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation never compared (due %0d)", q[0].name, q[0].due);
         void'(q.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
